// File: rtl/serial_out_scheduler.sv
// serial_out_scheduler: staggered per-channel start pulses, busy tracking, abort.
// Optional S_WAIT watchdog is compiled in when SCHED_WATCHDOG_EN is defined.
module serial_out_scheduler #(
  parameter int OUTPUT_NUM = 16,
  parameter int DELAY_BIT  = 16,
  parameter int WDT_CYCLES = 65535
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_cfg_we,
  input  logic [3:0]           i_cfg_sel,
  input  logic                 i_cfg_enable,
  input  logic [DELAY_BIT-1:0] i_cfg_delay,
  input  logic                 i_launch,
  input  logic                 i_abort,
  input  logic [15:0]          i_ch_done_tick,
  output logic [15:0]          o_start_tick,
  output logic [15:0]          o_stop,
  output logic [15:0]          o_busy,
  output logic                 o_sched_busy,
  output logic                 o_done_tick,
  output logic                 o_timeout
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_WAIT,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [15:0] en_q, en_d;
  logic [15:0] started_q, started_d;
  logic [15:0] busy_q, busy_d;
  logic [15:0] start_q, start_d;
  logic [15:0] stop_q, stop_d;

  logic [DELAY_BIT-1:0] dly_q [16];
  logic [DELAY_BIT-1:0] dly_d [16];
  logic [DELAY_BIT-1:0] cnt_q, cnt_d;

  logic done_q, done_d;
  logic sbusy_q, sbusy_d;
  logic tmo_q, tmo_d;

  logic [15:0] match;
  logic [15:0] fire;
  logic        cfg_ok;
  logic        abort;
  logic        wdt_hit;

  assign cfg_ok = ({1'b0, i_cfg_sel} < 5'(OUTPUT_NUM));

  always_comb begin
    match = '0;
    for (int j = 0; j < 16; j++) begin
      match[j] = (dly_q[j] == cnt_q);
    end
  end

`ifdef SCHED_WATCHDOG_EN
  localparam int WDT_W = $clog2(WDT_CYCLES + 1);

  logic [WDT_W-1:0] wdt_q, wdt_d;

  // Counter is zero on S_WAIT entry and counts edges spent in S_WAIT.
  always_comb begin
    wdt_d = '0;
    if (state_q == S_WAIT) begin
      wdt_d = wdt_q + WDT_W'(1);
    end
  end

  assign wdt_hit = (state_q == S_WAIT) &&
                   (busy_q != '0) &&
                   (wdt_q == WDT_W'(WDT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wdt_q <= '0;
    end else begin
      wdt_q <= wdt_d;
    end
  end
`else
  assign wdt_hit = 1'b0;
`endif

  assign abort = ((state_q != S_IDLE) && i_abort) || wdt_hit;

  always_comb begin
    state_d   = state_q;
    en_d      = en_q;
    dly_d     = dly_q;
    cnt_d     = cnt_q;
    started_d = started_q;
    busy_d    = busy_q & ~i_ch_done_tick;
    start_d   = '0;
    stop_d    = '0;
    done_d    = 1'b0;
    tmo_d     = 1'b0;
    fire      = '0;

    unique case (state_q)
      S_IDLE: begin
        if (i_cfg_we && cfg_ok) begin
          en_d[i_cfg_sel]  = i_cfg_enable;
          dly_d[i_cfg_sel] = i_cfg_delay;
        end
        if (i_launch) begin
          cnt_d     = '0;
          started_d = '0;
          if (en_q == '0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_RUN;
          end
        end
      end
      S_RUN: begin
        fire      = en_q & ~started_q & match;
        start_d   = fire;
        started_d = started_q | fire;
        busy_d    = busy_d | fire;
        cnt_d     = cnt_q + DELAY_BIT'(1);
        if ((en_q & ~(started_q | fire)) == '0) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (busy_q == '0) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort wins over any start match or done tick in the same cycle.
    if (abort) begin
      stop_d    = busy_q;
      busy_d    = '0;
      started_d = '0;
      start_d   = '0;
      done_d    = 1'b0;
      tmo_d     = wdt_hit;
      state_d   = S_IDLE;
    end

    sbusy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      en_q      <= '0;
      cnt_q     <= '0;
      started_q <= '0;
      busy_q    <= '0;
      start_q   <= '0;
      stop_q    <= '0;
      done_q    <= 1'b0;
      sbusy_q   <= 1'b0;
      tmo_q     <= 1'b0;
      for (int j = 0; j < 16; j++) begin
        dly_q[j] <= '0;
      end
    end else begin
      state_q   <= state_d;
      en_q      <= en_d;
      cnt_q     <= cnt_d;
      started_q <= started_d;
      busy_q    <= busy_d;
      start_q   <= start_d;
      stop_q    <= stop_d;
      done_q    <= done_d;
      sbusy_q   <= sbusy_d;
      tmo_q     <= tmo_d;
      dly_q     <= dly_d;
    end
  end

  assign o_start_tick = start_q;
  assign o_stop       = stop_q;
  assign o_busy       = busy_q;
  assign o_sched_busy = sbusy_q;
  assign o_done_tick  = done_q;
  assign o_timeout    = tmo_q;

endmodule
